// File: rtl/rc_pkg.sv
// Shared definitions for the RC window generator.
//   WIN_LEN      symbols per window
//   N1_W         width of the ones-per-window target (0..WIN_LEN)
//   N1_MAX       WIN_LEN at N1_W bits; targets above it are clamped
//   RC_ONE/ZERO  4-bit symbol codes driven on A/B/C
//   state_t      top-level FSM state encoding
//   clamp_n1()   saturates a requested target to N1_MAX
package rc_pkg;

    localparam int WIN_LEN = 256;
    localparam int N1_W    = 9;

    localparam logic [N1_W-1:0] N1_MAX  = N1_W'(WIN_LEN);
    localparam logic [3:0]      RC_ONE  = 4'd8;
    localparam logic [3:0]      RC_ZERO = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [N1_W-1:0] clamp_n1(input logic [N1_W-1:0] n1);
        return (n1 > N1_MAX) ? N1_MAX : n1;
    endfunction

endpackage

// File: rtl/rc_spread_acc.sv
// Spread-mode accumulator: distributes n1 ones evenly over a window.
// Only instantiated when RC_GEN_SPREAD_EN is defined.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   n1          ones-per-window target (already clamped, 0..256)
//   clear       treat the accumulator as zero for this step (window start)
//   step        commit the updated accumulator
//   rc          symbol for this step (combinational; registered by the top)
module rc_spread_acc
    import rc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N1_W-1:0] n1,
    input  logic            clear,
    input  logic            step,
    output logic            rc
);

    logic [N1_W-1:0] acc;
    logic [N1_W-1:0] base;
    logic [N1_W-1:0] sum;

    // acc stays below 256 and n1 is at most 256, so the sum fits in 9 bits.
    assign base = clear ? '0 : acc;
    assign sum  = base + n1;
    assign rc   = (sum >= N1_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (step) begin
            acc <= rc ? (sum - N1_MAX) : sum;
        end
    end

endmodule

// File: rtl/rc_window_gen.sv
// RC window generator: emits 256-cycle windows of RC symbols containing
// exactly n1 ones, either front-loaded (burst) or evenly spread.
// Build option: define RC_GEN_SPREAD_EN to include spread mode; without it
// cfg_mode is ignored and only burst mode exists.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   cfg_vld/cfg_rdy configuration handshake (rdy only in IDLE)
//   cfg_n1          target ones per window (clamped to 256)
//   cfg_mode        0 = burst, 1 = spread
//   cfg_windows     windows to emit, 0 = continuous until stop
//   stop            ends a continuous run at the next window boundary
//   A, B, C         symbol code (8 for RC=1, 0 for RC=0)
//   rc_bit          current symbol
//   win_first       first cycle of each window
//   busy            high while running
//   done            one-cycle pulse after the last window
//
// state | meaning
// IDLE  | waiting for a configuration, cfg_rdy high
// RUN   | emitting symbols, one per cycle
// DONE  | one cycle after the last window, done pulse
module rc_window_gen
    import rc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_vld,
    output logic            cfg_rdy,
    input  logic [N1_W-1:0] cfg_n1,
    input  logic            cfg_mode,
    input  logic [7:0]      cfg_windows,
    input  logic            stop,
    output logic [3:0]      A,
    output logic [3:0]      B,
    output logic [3:0]      C,
    output logic            rc_bit,
    output logic            win_first,
    output logic            busy,
    output logic            done
);

    state_t          state;
    logic [7:0]      cnt;
    logic [7:0]      cnt_nxt;
    logic [7:0]      win_left;
    logic [N1_W-1:0] n1;
    logic [N1_W-1:0] n1_eff;
    logic            stop_seen;
    logic            accept;
    logic            boundary;
    logic            last_win;
    logic            win_start;
    logic            burst_bit;
    logic            rc_nxt;
    logic [3:0]      sym_nxt;

    assign accept    = (state == IDLE) && cfg_vld && cfg_rdy;
    assign boundary  = (state == RUN) && (cnt == 8'd255);
    // win_left == 0 only ever happens in a continuous run.
    assign last_win  = (win_left == 8'd0) ? (stop_seen || stop) : (win_left == 8'd1);
    assign win_start = accept || (boundary && !last_win);
    assign cnt_nxt   = accept ? 8'd0 : cnt + 8'd1;
    // The accept edge already produces the cnt=0 symbol, so use the incoming config then.
    assign n1_eff    = (state == IDLE) ? clamp_n1(cfg_n1) : n1;
    assign burst_bit = ({1'b0, cnt_nxt} < n1_eff);

`ifdef RC_GEN_SPREAD_EN
    logic mode;
    logic mode_eff;
    logic spread_bit;

    assign mode_eff = (state == IDLE) ? cfg_mode : mode;

    rc_spread_acc u_spread (
        .clk   (clk),
        .rst_n (rst_n),
        .n1    (n1_eff),
        .clear (win_start),
        .step  (accept || (state == RUN)),
        .rc    (spread_bit)
    );

    assign rc_nxt = mode_eff ? spread_bit : burst_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 1'b0;
        end else if (accept) begin
            mode <= cfg_mode;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = cfg_mode;
    assign rc_nxt      = burst_bit;
`endif

    assign sym_nxt = rc_nxt ? RC_ONE : RC_ZERO;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            win_left  <= '0;
            n1        <= '0;
            stop_seen <= 1'b0;
            cfg_rdy   <= 1'b0;
            A         <= RC_ZERO;
            B         <= RC_ZERO;
            C         <= RC_ZERO;
            rc_bit    <= 1'b0;
            win_first <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    cfg_rdy <= 1'b1;
                    if (accept) begin
                        state     <= RUN;
                        cfg_rdy   <= 1'b0;
                        busy      <= 1'b1;
                        n1        <= n1_eff;
                        win_left  <= cfg_windows;
                        stop_seen <= 1'b0;
                        cnt       <= cnt_nxt;
                        win_first <= 1'b1;
                        rc_bit    <= rc_nxt;
                        A         <= sym_nxt;
                        B         <= sym_nxt;
                        C         <= sym_nxt;
                    end
                end
                RUN: begin
                    cnt <= cnt_nxt;
                    if (boundary && last_win) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        win_first <= 1'b0;
                        rc_bit    <= 1'b0;
                        A         <= RC_ZERO;
                        B         <= RC_ZERO;
                        C         <= RC_ZERO;
                    end else begin
                        win_first <= win_start;
                        rc_bit    <= rc_nxt;
                        A         <= sym_nxt;
                        B         <= sym_nxt;
                        C         <= sym_nxt;
                    end
                    if (boundary) begin
                        stop_seen <= 1'b0;
                        if (win_left != 8'd0) begin
                            win_left <= win_left - 8'd1;
                        end
                    end else if (stop) begin
                        stop_seen <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    cfg_rdy <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc_window_gen.sv
// Self-checking bench for rc_window_gen: a table of window runs checked
// cycle by cycle, plus a hand-written mid-run reset sequence.
module tb_rc_window_gen;

    logic       clk;
    logic       rst_n;
    logic       cfg_vld;
    logic       cfg_rdy;
    logic [8:0] cfg_n1;
    logic       cfg_mode;
    logic [7:0] cfg_windows;
    logic       stop;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] C;
    logic       rc_bit;
    logic       win_first;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

`ifdef RC_GEN_SPREAD_EN
    localparam bit SPREAD = 1'b1;
`else
    localparam bit SPREAD = 1'b0;
`endif

    rc_window_gen dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_vld     (cfg_vld),
        .cfg_rdy     (cfg_rdy),
        .cfg_n1      (cfg_n1),
        .cfg_mode    (cfg_mode),
        .cfg_windows (cfg_windows),
        .stop        (stop),
        .A           (A),
        .B           (B),
        .C           (C),
        .rc_bit      (rc_bit),
        .win_first   (win_first),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] n1;
        logic       mode;
        logic [7:0] windows;
        int         exp_wins;
        int         exp_ones;
        int         stop_at;
        bit         noise;
    } run_t;

    run_t runs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Spread: the k-th symbol is 1 when floor(k*n1/256) steps up at k+1.
    function automatic logic exp_bit(input int n1c, input logic sp, input int k);
        if (sp) return ((((k + 1) * n1c) / 256) - ((k * n1c) / 256)) != 0;
        return k < n1c;
    endfunction

    task automatic run_cfg(input int idx, input run_t r);
        int   n1c;
        logic sp;
        int   t;
        int   ones;
        int   errs;
        int   kt;
        logic e;
        n1c = (r.n1 > 9'd256) ? 256 : int'(r.n1);
        sp  = SPREAD && r.mode;
        t   = 0;
        while (!cfg_rdy && t < 20) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("run%0d_rdy", idx), {31'd0, cfg_rdy}, 32'd1);
        cfg_n1      = r.n1;
        cfg_mode    = r.mode;
        cfg_windows = r.windows;
        cfg_vld     = 1'b1;
        @(negedge clk);
        if (r.noise) begin
            cfg_n1      = 9'd3;
            cfg_mode    = ~r.mode;
            cfg_windows = 8'd9;
        end else begin
            cfg_vld = 1'b0;
        end
        kt = 0;
        for (int w = 0; w < r.exp_wins; w++) begin
            ones = 0;
            errs = 0;
            for (int k = 0; k < 256; k++) begin
                e = exp_bit(n1c, sp, k);
                if (rc_bit !== e || A !== (e ? 4'd8 : 4'd0) || B !== A || C !== A ||
                    win_first !== (k == 0) || busy !== 1'b1 || done !== 1'b0 || cfg_rdy !== 1'b0)
                    errs++;
                if (rc_bit === 1'b1) ones++;
                stop = (kt == r.stop_at);
                if (w == r.exp_wins - 1 && k == 255) cfg_vld = 1'b0;
                kt++;
                @(negedge clk);
            end
            check($sformatf("run%0d_win%0d_ones", idx, w), ones, r.exp_ones);
            check($sformatf("run%0d_win%0d_pattern_errs", idx, w), errs, 0);
        end
        stop = 1'b0;
        check($sformatf("run%0d_done", idx), {31'd0, done}, 32'd1);
        check($sformatf("run%0d_busy_end", idx), {31'd0, busy}, 32'd0);
        check($sformatf("run%0d_abc_end", idx), {20'd0, A, B, C}, 32'd0);
        check($sformatf("run%0d_rc_end", idx), {31'd0, rc_bit}, 32'd0);
        @(negedge clk);
        check($sformatf("run%0d_done_pulse", idx), {31'd0, done}, 32'd0);
        check($sformatf("run%0d_rdy_after", idx), {31'd0, cfg_rdy}, 32'd1);
    endtask

    initial begin
        int done_cnt;
        //            n1      mode  win    wins ones stop noise
        runs[0] = '{9'd256, 1'b0, 8'd1, 1, 256,  -1, 1'b0};
        runs[1] = '{9'd0,   1'b0, 8'd1, 1,   0,  -1, 1'b0};
        runs[2] = '{9'd128, 1'b1, 8'd2, 2, 128,  -1, 1'b0};
        runs[3] = '{9'd300, 1'b0, 8'd1, 1, 256,  -1, 1'b0};
        runs[4] = '{9'd5,   1'b0, 8'd3, 3,   5,  -1, 1'b1};
        runs[5] = '{9'd77,  1'b1, 8'd0, 2,  77, 356, 1'b0};
        runs[6] = '{9'd1,   1'b1, 8'd1, 1,   1,  -1, 1'b0};
        runs[7] = '{9'd255, 1'b0, 8'd2, 2, 255,  -1, 1'b0};
        runs[8] = '{9'd200, 1'b0, 8'd0, 1, 200, 255, 1'b0};

        rst_n       = 1'b0;
        cfg_vld     = 1'b0;
        cfg_n1      = 9'd0;
        cfg_mode    = 1'b0;
        cfg_windows = 8'd0;
        stop        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cfg_rdy", {31'd0, cfg_rdy}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_abc", {20'd0, A, B, C}, 32'd0);
        check("rst_rc_bit", {31'd0, rc_bit}, 32'd0);
        check("rst_win_first", {31'd0, win_first}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rdy_before_first_edge", {31'd0, cfg_rdy}, 32'd0);
        @(negedge clk);
        check("rdy_first_edge", {31'd0, cfg_rdy}, 32'd1);

        for (int i = 0; i < 9; i++) run_cfg(i, runs[i]);

        // Continuous burst run, aborted by reset at cnt=50.
        cfg_n1      = 9'd77;
        cfg_mode    = 1'b0;
        cfg_windows = 8'd0;
        cfg_vld     = 1'b1;
        @(negedge clk);
        cfg_vld = 1'b0;
        check("abort_first", {31'd0, win_first}, 32'd1);
        repeat (50) @(negedge clk);
        check("abort_pre_rc", {31'd0, rc_bit}, 32'd1);
        check("abort_pre_abc", {20'd0, A, B, C}, {20'd0, 12'h888});
        check("abort_pre_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_abc", {20'd0, A, B, C}, 32'd0);
        check("abort_rc", {31'd0, rc_bit}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rdy", {31'd0, cfg_rdy}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_rdy_after", {31'd0, cfg_rdy}, 32'd1);
        check("abort_idle_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rc_window_gen.md
RC_WINDOW_GEN -- requirements
Module: rc_window_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 cfg_vld  in  1  configuration request.
REQ-003 cfg_rdy  out  1  configuration accept; high only in IDLE.
REQ-004 cfg_n1  in  9  target count of RC=1 symbols per 256-cycle window; values above 256 are clamped to 256.
REQ-005 cfg_mode  in  1  0 = burst, 1 = spread.
REQ-006 cfg_windows  in  8  number of windows to emit; 0 = continuous.
REQ-007 stop  in  1  ends continuous run at the next window boundary.
REQ-008 A, B, C  out  4 each  symbol code: 4'd8 each for RC=1, 4'd0 each for RC=0.
REQ-009 rc_bit  out  1  symbol currently on A/B/C.
REQ-010 win_first  out  1  high during the first cycle of each window.
REQ-011 busy  out  1  high in RUN.
REQ-012 done  out  1  one-cycle pulse after the last window.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 Transitions: IDLE->RUN on cfg_vld&&cfg_rdy; RUN->DONE at the window boundary when no windows remain; DONE->IDLE after one cycle unconditionally.
REQ-015 On accept, the block SHALL latch cfg_n1 (clamped), cfg_mode and cfg_windows, and clear the 8-bit window counter cnt and the 9-bit accumulator acc.
REQ-016 All outputs SHALL be registered.
REQ-017 The symbol for cnt=0 SHALL be driven by the accept edge, so win_first=1 in the first cycle after accept.
REQ-018 cnt SHALL increment every RUN cycle and wrap 255->0; each wrap starts a new window with win_first=1.
REQ-019 Burst mode: rc_bit=1 iff cnt < n1.
REQ-020 Spread mode: s = acc + n1 each cycle; if s >= 256 then rc_bit=1 and acc = s-256, else rc_bit=0 and acc = s.
REQ-021 acc SHALL be cleared at every window start.
REQ-022 Both modes SHALL produce exactly n1 ones per 256-cycle window for every n1 in 0..256.
REQ-023 Spread mode with n1=128 SHALL produce the sequence 0,1,0,1,...
REQ-024 A window in progress SHALL always complete; stop and the window count act only at the cnt=255 boundary.
REQ-025 A nonzero cfg_windows SHALL be decremented at each boundary; when it reaches 0 the block SHALL go to DONE.
REQ-026 When cfg_windows=0, the block SHALL go to DONE at the first boundary at which stop has been sampled high since the previous boundary.
REQ-027 In IDLE and DONE, A/B/C/rc_bit SHALL be 0 and win_first SHALL be 0.
REQ-028 cfg_vld outside IDLE SHALL be ignored without side effects.

Reset
REQ-029 While rst_n=0, the block SHALL be in IDLE with cnt=0, acc=0, A=B=C=0, rc_bit=0, win_first=0, busy=0, done=0 and cfg_rdy=0.
REQ-030 cfg_rdy SHALL rise on the first clock edge after rst_n deasserts.
REQ-031 Reset asserted mid-RUN SHALL abort immediately; no done pulse SHALL follow.

Configuration
REQ-032 Macro RC_GEN_SPREAD_EN defined: spread mode and the acc datapath SHALL be present.
REQ-033 Macro RC_GEN_SPREAD_EN undefined: cfg_mode SHALL be ignored, the block SHALL always run burst mode, and no accumulator logic SHALL be synthesized.

Structure
REQ-034 Shared package rc_pkg SHALL hold: WIN_LEN=256, N1_W=9, the RC_ONE/RC_ZERO 4-bit codes, and the FSM state enum.
REQ-035 The spread accumulator SHALL be one sub-module, rc_spread_acc (inputs n1, clear, step; output bit), instantiated only under RC_GEN_SPREAD_EN.

Verification
REQ-036 Burst, n1=256, windows=1 -> 256 cycles of A=B=C=8, then done=1 for one cycle, then cfg_rdy=1.
REQ-037 Burst, n1=0, windows=1 -> 256 cycles of A=B=C=0, win_first only in the first cycle, then done.
REQ-038 Spread, n1=128, windows=2 -> alternating 0,1 pattern; 128 ones per window; win_first at cycles 0 and 256.
REQ-039 Burst, n1=300, windows=1 -> clamped; 256 ones.
REQ-040 Burst, n1=5, windows=3 -> ones at cnt 0..4 of each window; done 768 cycles after the first symbol.
REQ-041 Continuous, n1=77 spread, stop pulsed at cnt=100 of window 2 -> window 2 completes with 77 ones; done follows; reset asserted at cnt=50 of a later run -> outputs 0 immediately and no done pulse.
